// File: rtl/count_checker.sv
// count_checker: predicts an up/down counter's next value from its sampled
// inputs and flags, counts and recovers from deviations.
module count_checker #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int RELOCK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_enable,
    input  logic             i_count_dir,
    input  logic             i_dut_reset,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_count,
    output logic [WIDTH-1:0] o_expected,
    output logic [1:0]       o_state
);
    localparam int GW = $clog2(RELOCK + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_t;

    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_expected, w_pred;
    logic [ERR_W-1:0] r_err_count;
    logic [GW-1:0]    r_good_run;
    logic             r_err_pulse, w_mismatch, w_relock;

    // Prediction wraps naturally modulo 2^WIDTH.
    always_comb begin
        w_pred = i_dut_reset ? '0 :
                 !i_enable   ? i_count :
                 i_count_dir ? i_count + WIDTH'(1) : i_count - WIDTH'(1);
        w_mismatch = (r_state != IDLE) && (i_count != r_expected);
        w_relock   = (r_state == FAULT) && !w_mismatch && (r_good_run == GW'(RELOCK - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next_state;

    always_comb
        w_next_state = i_clear                          ? IDLE  :
                       w_mismatch                       ? FAULT :
                       (r_state == FAULT && !w_relock)  ? FAULT : TRACK;

    always_comb begin
        o_locked    = (r_state == TRACK);
        o_state     = r_state;
        o_err_pulse = r_err_pulse;
        o_err_count = r_err_count;
        o_expected  = r_expected;
    end

    // clear wins over a simultaneous mismatch; expected keeps resyncing regardless.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_expected  <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_good_run  <= '0;
        end else begin
            r_expected  <= w_pred;
            r_err_pulse <= !i_clear && w_mismatch;
            r_err_count <= i_clear ? '0 :
                           (w_mismatch && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;
            r_good_run  <= (i_clear || w_mismatch || w_relock || r_state != FAULT) ? '0 :
                           r_good_run + GW'(1);
        end
endmodule
